// File: rtl/uart_tx_sched.sv
// Arbitrates the single TX FIFO push port between a one-deep echo buffer and
// an atomic "HH:MM:SS\r\n" time-report frame built from a BCD snapshot.
module uart_tx_sched #(
    parameter bit          RPT_CRLF = 1'b1,
    parameter logic [7:0]  SEP_CHAR = 8'h3A,
    parameter int          DROP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              echo_valid,
    input  logic [7:0]        echo_data,
    output logic              echo_ready,
    input  logic              rpt_req,
    input  logic [7:0]        hh_bcd,
    input  logic [7:0]        mm_bcd,
    input  logic [7:0]        ss_bcd,
    output logic              rpt_busy,
    input  logic              fifo_full,
    output logic              fifo_push,
    output logic [7:0]        fifo_wdata,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ECHO = 2'd1,
        RPT  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = RPT_CRLF ? 4'd9 : 4'd7;

    state_t            state_r;
    logic [3:0]        idx_r;
    logic [7:0]        snap_hh_r;
    logic [7:0]        snap_mm_r;
    logic [7:0]        snap_ss_r;
    logic              echo_full_r;
    logic [7:0]        echo_buf_r;
    logic              pend_r;
    logic [DROP_W-1:0] drop_cnt_r;

    logic              push_s;
    logic              echo_accept_s;
    logic              echo_drop_s;
    logic              echo_done_s;
    logic              start_rpt_s;
    logic [7:0]        rpt_byte_s;
    logic [7:0]        wdata_s;

    // A BCD digit outside 0..9 is shown as '?' rather than a misleading glyph.
    function automatic logic [7:0] bcd_ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib > 4'd9) begin
            res = 8'h3F;
        end else begin
            res = 8'h30 + {4'h0, nib};
        end
        return res;
    endfunction

    assign push_s        = (state_r != IDLE) && !fifo_full;
    assign echo_accept_s = echo_valid && !echo_full_r;
    assign echo_drop_s   = echo_valid && echo_full_r;
    assign echo_done_s   = (state_r == ECHO) && push_s;
    // Echo has priority, so a pending report only starts with an empty buffer.
    assign start_rpt_s   = (state_r == IDLE) && !echo_full_r && pend_r;

    // Frame byte selected by index from the snapshot taken at frame start.
    always_comb begin
        rpt_byte_s = 8'h00;
        case (idx_r)
            4'd0:    rpt_byte_s = bcd_ascii(snap_hh_r[7:4]);
            4'd1:    rpt_byte_s = bcd_ascii(snap_hh_r[3:0]);
            4'd2:    rpt_byte_s = SEP_CHAR;
            4'd3:    rpt_byte_s = bcd_ascii(snap_mm_r[7:4]);
            4'd4:    rpt_byte_s = bcd_ascii(snap_mm_r[3:0]);
            4'd5:    rpt_byte_s = SEP_CHAR;
            4'd6:    rpt_byte_s = bcd_ascii(snap_ss_r[7:4]);
            4'd7:    rpt_byte_s = bcd_ascii(snap_ss_r[3:0]);
            4'd8:    rpt_byte_s = 8'h0D;
            4'd9:    rpt_byte_s = 8'h0A;
            default: rpt_byte_s = 8'h00;
        endcase
    end

    // Write data mux; held stable through fifo_full stalls since it only depends on registers.
    always_comb begin
        wdata_s = 8'h00;
        case (state_r)
            IDLE:    wdata_s = 8'h00;
            ECHO:    wdata_s = echo_buf_r;
            RPT:     wdata_s = rpt_byte_s;
            default: wdata_s = 8'h00;
        endcase
    end

    // Scheduler FSM with frame index and time snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            idx_r     <= 4'd0;
            snap_hh_r <= 8'h00;
            snap_mm_r <= 8'h00;
            snap_ss_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (echo_full_r) begin
                        state_r <= ECHO;
                    end else if (pend_r) begin
                        state_r   <= RPT;
                        idx_r     <= 4'd0;
                        snap_hh_r <= hh_bcd;
                        snap_mm_r <= mm_bcd;
                        snap_ss_r <= ss_bcd;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ECHO: begin
                    if (push_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= ECHO;
                    end
                end
                RPT: begin
                    if (push_s && (idx_r == LAST_IDX)) begin
                        state_r <= IDLE;
                        idx_r   <= 4'd0;
                    end else if (push_s) begin
                        idx_r <= idx_r + 4'd1;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= 4'd0;
                end
            endcase
        end
    end

    // One-deep echo buffer: filled on handshake, emptied when its byte is pushed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            echo_full_r <= 1'b0;
            echo_buf_r  <= 8'h00;
        end else if (echo_accept_s) begin
            echo_full_r <= 1'b1;
            echo_buf_r  <= echo_data;
        end else if (echo_done_s) begin
            echo_full_r <= 1'b0;
        end else begin
            echo_full_r <= echo_full_r;
        end
    end

    // Report pending flag; a request coinciding with frame start re-arms it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_r <= 1'b0;
        end else if (rpt_req) begin
            pend_r <= 1'b1;
        end else if (start_rpt_s) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    // Saturating count of echo bytes refused while the buffer was occupied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_r <= '0;
        end else if (echo_drop_s && !(&drop_cnt_r)) begin
            drop_cnt_r <= drop_cnt_r + {{(DROP_W-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign echo_ready = !echo_full_r;
    assign rpt_busy   = pend_r || (state_r == RPT);
    assign fifo_push  = push_s;
    assign fifo_wdata = wdata_s;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus queues expected TX bytes,
// a negedge monitor pops and compares on every fifo_push.
module tb_uart_tx_sched;

    logic       clk;
    logic       rst;
    logic       echo_valid;
    logic [7:0] echo_data;
    logic       echo_ready;
    logic       rpt_req;
    logic [7:0] hh_bcd;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;
    logic       rpt_busy;
    logic       fifo_full;
    logic       fifo_push;
    logic [7:0] fifo_wdata;
    logic [7:0] drop_cnt;

    int n_cmp;
    int n_fail;
    logic [7:0] exp_q[$];
    logic [7:0] fv[10];

    uart_tx_sched #(.RPT_CRLF(1'b1), .SEP_CHAR(8'h3A), .DROP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .echo_valid (echo_valid),
        .echo_data  (echo_data),
        .echo_ready (echo_ready),
        .rpt_req    (rpt_req),
        .hh_bcd     (hh_bcd),
        .mm_bcd     (mm_bcd),
        .ss_bcd     (ss_bcd),
        .rpt_busy   (rpt_busy),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_wdata (fifo_wdata),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [7:0] v[10], input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    task automatic wait_idle(input string name, input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            done = (exp_q.size() == 0) && !rpt_busy && echo_ready && !fifo_push;
            if (done) break;
            step();
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every push must match the next expected byte.
    always @(negedge clk) begin
        if (fifo_push === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_push", {24'd0, fifo_wdata}, 32'hFFFF_FFFF);
            end else begin
                chk("push_byte", {24'd0, fifo_wdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        echo_valid = 1'b0;
        echo_data = 8'h00;
        rpt_req = 1'b0;
        hh_bcd = 8'h00;
        mm_bcd = 8'h00;
        ss_bcd = 8'h00;
        fifo_full = 1'b0;
        repeat (3) step();

        chk("rst_echo_ready", {31'd0, echo_ready}, 32'd1);
        chk("rst_rpt_busy",   {31'd0, rpt_busy},   32'd0);
        chk("rst_fifo_push",  {31'd0, fifo_push},  32'd0);
        chk("rst_wdata",      {24'd0, fifo_wdata}, 32'h00);
        chk("rst_drop_cnt",   {24'd0, drop_cnt},   32'h00);
        rst = 1'b1;
        step();

        // Echo 0x30: push two cycles after echo_valid.
        exp_q.push_back(8'h30);
        echo_valid = 1'b1;
        echo_data = 8'h30;
        step();
        echo_valid = 1'b0;
        chk("echo_n1_ready", {31'd0, echo_ready}, 32'd0);
        chk("echo_n1_push",  {31'd0, fifo_push},  32'd0);
        step();
        chk("echo_n2_ready", {31'd0, echo_ready}, 32'd0);
        chk("echo_n2_push",  {31'd0, fifo_push},  32'd1);
        step();
        chk("echo_n3_ready", {31'd0, echo_ready}, 32'd1);
        chk("echo_n3_push",  {31'd0, fifo_push},  32'd0);
        wait_idle("drain_echo", 20);

        // Basic report 12:34:56, ten consecutive pushes.
        hh_bcd = 8'h12; mm_bcd = 8'h34; ss_bcd = 8'h56;
        fv = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
        push_vec(fv, 10);
        rpt_req = 1'b1;
        step();
        rpt_req = 1'b0;
        chk("rpt_n1_busy", {31'd0, rpt_busy},  32'd1);
        chk("rpt_n1_push", {31'd0, fifo_push}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rpt_consec_push", {31'd0, fifo_push}, 32'd1);
            chk("rpt_busy_in",     {31'd0, rpt_busy},  32'd1);
        end
        step();
        chk("rpt_end_busy", {31'd0, rpt_busy},  32'd0);
        chk("rpt_end_push", {31'd0, fifo_push}, 32'd0);

        // Same frame under alternating fifo_full and mid-frame input changes.
        push_vec(fv, 10);
        rpt_req = 1'b1;
        step();
        rpt_req = 1'b0;
        for (int c = 0; c < 80; c++) begin
            fifo_full = (c % 2 == 0);
            if (c == 5) begin
                hh_bcd = 8'h99; mm_bcd = 8'h88; ss_bcd = 8'h77;
            end
            step();
            if (exp_q.size() == 0) break;
        end
        fifo_full = 1'b0;
        wait_idle("drain_stall", 40);

        // Echo during a frame: first buffered, next two dropped.
        hh_bcd = 8'h23; mm_bcd = 8'h59; ss_bcd = 8'h07;
        fv = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h30, 8'h37, 8'h0D, 8'h0A};
        push_vec(fv, 10);
        exp_q.push_back(8'h41);
        rpt_req = 1'b1;
        step();
        rpt_req = 1'b0;
        repeat (2) step();
        echo_valid = 1'b1; echo_data = 8'h41;
        step();
        echo_data = 8'h42;
        step();
        echo_data = 8'h43;
        step();
        echo_valid = 1'b0;
        wait_idle("drain_echo_in_rpt", 40);
        chk("drop_cnt_two", {24'd0, drop_cnt}, 32'd2);

        // Simultaneous echo and report: echo first; invalid BCD digit shows '?'.
        hh_bcd = 8'h1A; mm_bcd = 8'h00; ss_bcd = 8'h09;
        exp_q.push_back(8'h55);
        fv = '{8'h31, 8'h3F, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h39, 8'h0D, 8'h0A};
        push_vec(fv, 10);
        rpt_req = 1'b1;
        echo_valid = 1'b1; echo_data = 8'h55;
        step();
        rpt_req = 1'b0;
        echo_valid = 1'b0;
        wait_idle("drain_simul", 40);

        // Drop counter saturates while the buffer is stuck behind a full FIFO.
        fifo_full = 1'b1;
        exp_q.push_back(8'h66);
        echo_valid = 1'b1; echo_data = 8'h66;
        repeat (262) step();
        echo_valid = 1'b0;
        chk("drop_sat",       {24'd0, drop_cnt},   32'hFF);
        chk("stall_wdata",    {24'd0, fifo_wdata}, 32'h66);
        chk("stall_no_push",  {31'd0, fifo_push},  32'd0);
        fifo_full = 1'b0;
        wait_idle("drain_sat", 20);

        // Reset at frame byte 4 abandons the frame.
        hh_bcd = 8'h08; mm_bcd = 8'h15; ss_bcd = 8'h42;
        fv = '{8'h30, 8'h38, 8'h3A, 8'h31, 8'h35, 8'h3A, 8'h34, 8'h32, 8'h0D, 8'h0A};
        push_vec(fv, 5);
        rpt_req = 1'b1;
        step();
        rpt_req = 1'b0;
        repeat (5) step();
        chk("byte4_present", {24'd0, fifo_wdata}, 32'h35);
        rst = 1'b0;
        step();
        chk("mid_rst_push",   {31'd0, fifo_push},  32'd0);
        chk("mid_rst_busy",   {31'd0, rpt_busy},   32'd0);
        chk("mid_rst_drop",   {24'd0, drop_cnt},   32'd0);
        chk("mid_rst_ready",  {31'd0, echo_ready}, 32'd1);
        chk("mid_rst_wdata",  {24'd0, fifo_wdata}, 32'h00);
        chk("mid_rst_q",      exp_q.size(),        32'd0);
        rst = 1'b1;
        step();
        push_vec(fv, 10);
        rpt_req = 1'b1;
        step();
        rpt_req = 1'b0;
        wait_idle("drain_after_rst", 40);

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares the single UART TX FIFO push port between two requesters.
  - Echo path: bytes received on RX are echoed back.
  - Report path: an ASCII time frame "HH:MM:SS\r\n" is built from the watch BCD counters.
- Sits between the RX/watch logic and the TX FIFO write side inside the UART watch top.
- Report frames are atomic. Echo bytes are single-byte transfers buffered one deep.

Parameters:
- RPT_CRLF, 1, 1: frame ends with 0x0D,0x0A (10 bytes); 0: no terminator (8 bytes).
- SEP_CHAR, 8'h3A, separator byte between field pairs (':').
- DROP_W, 8, width of the saturating echo drop counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- echo_valid  in  1  echo byte offered this cycle.
- echo_data  in  8  echo byte.
- echo_ready  out  1  echo buffer empty; a byte is accepted when echo_valid && echo_ready.
- rpt_req  in  1  single-cycle request for one report frame.
- hh_bcd  in  8  hours, two BCD nibbles [7:4] tens, [3:0] units.
- mm_bcd  in  8  minutes, BCD.
- ss_bcd  in  8  seconds, BCD.
- rpt_busy  out  1  report pending or in progress.
- fifo_full  in  1  TX FIFO full; no push allowed.
- fifo_push  out  1  write strobe to TX FIFO.
- fifo_wdata  out  8  byte written on fifo_push.
- drop_cnt  out  DROP_W  count of echo bytes refused, saturating.

Behaviour:
- Reset (rst=0 at an edge), from any state, mid-frame included:
  - state=IDLE, echo buffer empty, report pending cleared, byte index=0, snapshot=0, drop_cnt=0.
  - Outputs: echo_ready=1, rpt_busy=0, fifo_push=0, fifo_wdata=0x00.
  - A partially sent frame is abandoned, not resumed.
- State machine: IDLE, ECHO, RPT (registered).
- fifo_push = (state!=IDLE) && !fifo_full, combinational from registers.
  - fifo_wdata is valid whenever state!=IDLE; it is 0x00 in IDLE.
- Echo buffer:
  - Captures echo_data at the edge where echo_valid && echo_ready.
  - echo_ready = buffer empty.
  - echo_valid && !echo_ready increments drop_cnt, saturating at all-ones.
- Report pending flag:
  - Set on rpt_req.
  - Cleared on the IDLE->RPT transition, unless rpt_req is high in that same cycle; then it stays set.
  - A rpt_req while the flag is already set merges (no extra frame).
  - rpt_busy = pending || state==RPT.
- IDLE, priority order:
  - Echo buffer full -> ECHO.
  - Otherwise pending -> RPT: snapshot hh/mm/ss at this edge, index=0.
  - Otherwise stay in IDLE.
- ECHO:
  - fifo_wdata = buffer.
  - On the edge with fifo_push=1: buffer emptied, -> IDLE.
  - While fifo_full, hold state and data.
- RPT:
  - fifo_wdata selected by index:
    - 0,1 hh tens, hh units
    - 2 SEP_CHAR
    - 3,4 mm tens, mm units
    - 5 SEP_CHAR
    - 6,7 ss tens, ss units
    - 8,9 0x0D, 0x0A
  - Digit encoding: 0x30+nibble; a nibble >9 encodes as 0x3F ('?').
  - Index advances on each push. The push of the last byte (index 9, or 7 when RPT_CRLF=0) -> IDLE, index=0.
  - fifo_full stalls with index and data held.
  - Input changes during a frame do not affect it (snapshot is used).
- Echo bytes arriving during RPT are buffered (one only) and sent after the frame ends; further bytes are dropped and counted.
- Latency:
  - Echo: echo_valid at cycle N with empty buffer and IDLE -> buffer full at N+1, ECHO at N+2, push at N+2 if !fifo_full.
  - Report: rpt_req at N with IDLE and no echo -> pending at N+1, RPT at N+2, first push at N+2.
- Back-to-back reports: a pending report with an empty echo buffer starts one cycle after the previous frame's last push (one IDLE cycle between frames).
- Simultaneous echo and report pending in IDLE: echo goes first.
- No byte is pushed twice and no frame byte is skipped under any fifo_full pattern.

Test Plan:
- Echo 0x30 with fifo_full=0 -> exactly one fifo_push, wdata=0x30, 2 cycles after echo_valid; echo_ready low for 2 cycles.
- rpt_req with hh=0x12, mm=0x34, ss=0x56 -> 10 consecutive pushes: 31 32 3A 33 34 3A 35 36 0D 0A; rpt_busy high from N+1 until after the last push.
- Same report with fifo_full toggled 1/0 every other cycle, and hh/mm/ss changed mid-frame -> identical byte sequence, no duplicates, snapshot values only.
- Echo 0x41 during a frame, then 0x42, 0x43 before the frame ends -> frame intact, then a single push of 0x41; drop_cnt=2.
- rpt_req and echo_valid(0x55) in the same cycle from IDLE -> 0x55 pushed first, then the full frame; hh=0x1A -> bytes 0 and 1 = 0x31, 0x3F.
- rst=0 asserted at frame byte 4 -> next cycle: fifo_push=0, rpt_busy=0, drop_cnt=0, echo_ready=1. A new rpt_req after release -> complete frame starting at byte 0.
